// File: rtl/pattern_string_gen.sv
// pattern_string_gen
//  Emits one framed test string per accepted start as a valid/ready byte
//  stream: 0x00, finance symbol, N_DIGITS digits, math symbol, N_CAPS
//  capitals, 0x00. Characters come from an 8-bit LFSR stepped on every
//  handshake. A byte position can be replaced by ERR_CHAR to build a
//  known-bad string; o_expect_ok reports which kind is being sent.
//  LEN = N_DIGITS + N_CAPS + 4 must not exceed 16 (4-bit byte index).
// Ports
//  i_clk        clock, all logic on rising edge
//  i_rst        synchronous active-high reset
//  i_start      request one string, sampled only while idle
//  i_seed       LFSR seed, latched on accept (0 is replaced by 8'h01)
//  i_err_pos    byte index to corrupt, latched on accept
//  i_ready      consumer takes o_data this cycle when o_valid=1
//  o_data       current byte
//  o_valid      o_data is valid
//  o_busy       string in progress, accept through last handshake
//  o_done       one-cycle pulse after the closing 0x00 handshake
//  o_expect_ok  1 when the current/last string is well-formed
module pattern_string_gen #(
    parameter int unsigned N_DIGITS = 3,
    parameter int unsigned N_CAPS   = 2,
    parameter logic [7:0]  ERR_CHAR = 8'h7E
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [7:0] i_seed,
    input  logic [3:0] i_err_pos,
    input  logic       i_ready,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_expect_ok
);

    localparam int unsigned LEN          = N_DIGITS + N_CAPS + 4;
    localparam logic [3:0]  LAST_IDX     = 4'(LEN - 1);
    localparam logic [3:0]  DIG_RUN_LAST = 4'(N_DIGITS - 1);
    localparam logic [3:0]  CAP_RUN_LAST = 4'(N_CAPS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SOF,
        S_FIN,
        S_DIG,
        S_MATH,
        S_CAP,
        S_EOF
    } state_t;

    state_t     r_state,  w_state_nxt;
    logic [7:0] r_lfsr,   w_lfsr_nxt;
    logic [3:0] r_idx,    w_idx_nxt;
    logic [3:0] r_run,    w_run_nxt;
    logic [3:0] r_err_pos, w_err_pos_nxt;
    logic       r_inject, w_inject_nxt;
    logic [7:0] r_data,   w_data_nxt;
    logic       r_valid,  w_valid_nxt;
    logic       r_busy,   w_busy_nxt;
    logic       r_done,   w_done_nxt;
    logic       r_expect_ok, w_expect_ok_nxt;

    logic       w_hs;
    logic       w_start_inject;

    // Fibonacci step: shift left, feedback taps 7,5,4,3
    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    // Character for a given field, drawn from the LFSR value of that byte
    function automatic logic [7:0] char_for(input state_t s, input logic [7:0] r);
        logic [7:0] c;
        c = 8'h00;
        case (s)
            S_FIN: begin
                case (r[2:0])
                    3'd0:    c = 8'h23;  // #
                    3'd1:    c = 8'h24;  // $
                    3'd2:    c = 8'h25;  // %
                    3'd3:    c = 8'h26;  // &
                    3'd4:    c = 8'h40;  // @
                    3'd5:    c = 8'h23;  // #
                    3'd6:    c = 8'h24;  // $
                    default: c = 8'h25;  // %
                endcase
            end
            S_DIG: begin
                if (r[3:0] >= 4'd10) c = 8'h30 + 8'(r[3:0] - 4'd10);
                else                 c = 8'h30 + 8'(r[3:0]);
            end
            S_MATH: begin
                case (r[2:0])
                    3'd0:    c = 8'h2B;  // +
                    3'd1:    c = 8'h2D;  // -
                    3'd2:    c = 8'h2A;  // *
                    3'd3:    c = 8'h2F;  // /
                    3'd4:    c = 8'h5C;  // backslash
                    3'd5:    c = 8'h3D;  // =
                    3'd6:    c = 8'h3C;  // <
                    default: c = 8'h3E;  // >
                endcase
            end
            S_CAP: begin
                if (r[4:0] >= 5'd26) c = 8'h41 + 8'(r[4:0] - 5'd26);
                else                 c = 8'h41 + 8'(r[4:0]);
            end
            default: c = 8'h00;  // delimiters
        endcase
        return c;
    endfunction

    assign w_hs = r_valid && i_ready;

    // Only interior bytes may be corrupted; delimiters stay intact
    assign w_start_inject = (i_err_pos != 4'd0) && (i_err_pos < LAST_IDX);

    // State and datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_lfsr      <= 8'h01;
            r_idx       <= 4'd0;
            r_run       <= 4'd0;
            r_err_pos   <= 4'd0;
            r_inject    <= 1'b0;
            r_data      <= 8'h00;
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_expect_ok <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_lfsr      <= w_lfsr_nxt;
            r_idx       <= w_idx_nxt;
            r_run       <= w_run_nxt;
            r_err_pos   <= w_err_pos_nxt;
            r_inject    <= w_inject_nxt;
            r_data      <= w_data_nxt;
            r_valid     <= w_valid_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_expect_ok <= w_expect_ok_nxt;
        end
    end

    // Next-state and next-output logic; the following byte is loaded on the
    // handshake edge so the stream has no bubbles while i_ready stays high
    always_comb begin
        w_state_nxt     = r_state;
        w_lfsr_nxt      = r_lfsr;
        w_idx_nxt       = r_idx;
        w_run_nxt       = r_run;
        w_err_pos_nxt   = r_err_pos;
        w_inject_nxt    = r_inject;
        w_data_nxt      = r_data;
        w_valid_nxt     = r_valid;
        w_busy_nxt      = r_busy;
        w_done_nxt      = 1'b0;
        w_expect_ok_nxt = r_expect_ok;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt     = S_SOF;
                    w_lfsr_nxt      = (i_seed == 8'h00) ? 8'h01 : i_seed;
                    w_idx_nxt       = 4'd0;
                    w_run_nxt       = 4'd0;
                    w_err_pos_nxt   = i_err_pos;
                    w_inject_nxt    = w_start_inject;
                    w_expect_ok_nxt = !w_start_inject;
                    w_data_nxt      = 8'h00;
                    w_valid_nxt     = 1'b1;
                    w_busy_nxt      = 1'b1;
                end
            end
            default: begin
                if (w_hs) begin
                    if (r_state == S_EOF) begin
                        w_state_nxt = S_IDLE;
                        w_data_nxt  = 8'h00;
                        w_valid_nxt = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        case (r_state)
                            S_SOF: w_state_nxt = S_FIN;
                            S_FIN: begin
                                w_state_nxt = S_DIG;
                                w_run_nxt   = 4'd0;
                            end
                            S_DIG: begin
                                if (r_run == DIG_RUN_LAST) w_state_nxt = S_MATH;
                                else                       w_run_nxt   = r_run + 4'd1;
                            end
                            S_MATH: begin
                                w_state_nxt = S_CAP;
                                w_run_nxt   = 4'd0;
                            end
                            S_CAP: begin
                                if (r_run == CAP_RUN_LAST) w_state_nxt = S_EOF;
                                else                       w_run_nxt   = r_run + 4'd1;
                            end
                            default: w_state_nxt = S_IDLE;
                        endcase
                        w_lfsr_nxt = lfsr_step(r_lfsr);
                        w_idx_nxt  = r_idx + 4'd1;
                        if (r_inject && (w_idx_nxt == r_err_pos))
                            w_data_nxt = ERR_CHAR;
                        else
                            w_data_nxt = char_for(w_state_nxt, w_lfsr_nxt);
                    end
                end
            end
        endcase
    end

    assign o_data      = r_data;
    assign o_valid     = r_valid;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_expect_ok = r_expect_ok;

endmodule

// File: tb/tb_pattern_string_gen.sv
// tb_pattern_string_gen
//  Drives pattern_string_gen with directed and randomized strings and
//  compares every byte against a reference built from the string rules.
module tb_pattern_string_gen;

    localparam int ND  = 3;
    localparam int NC  = 2;
    localparam int LEN = ND + NC + 4;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] seed;
    logic [3:0] err_pos;
    logic       ready;
    logic [7:0] data;
    logic       valid;
    logic       busy;
    logic       done;
    logic       expect_ok;

    int n_cmp;
    int n_bad;

    logic [7:0] exp_q [LEN];
    logic [7:0] got_q [LEN];
    logic [7:0] lit_q [LEN];

    pattern_string_gen #(
        .N_DIGITS (ND),
        .N_CAPS   (NC),
        .ERR_CHAR (8'h7E)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_seed      (seed),
        .i_err_pos   (err_pos),
        .i_ready     (ready),
        .o_data      (data),
        .o_valid     (valid),
        .o_busy      (busy),
        .o_done      (done),
        .o_expect_ok (expect_ok)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference string built from the field layout and LFSR rule
    task automatic build_exp(input logic [7:0] s, input logic [3:0] ep);
        string fin;
        string mth;
        logic [7:0] l;
        int r;
        fin = "#$%&@#$%";
        mth = "+-*/\\=<>";
        l = (s == 8'h00) ? 8'h01 : s;
        for (int i = 0; i < LEN; i++) begin
            r = int'(l);
            if (i == 0 || i == LEN - 1)  exp_q[i] = 8'h00;
            else if (i == 1)             exp_q[i] = fin[r % 8];
            else if (i <= 1 + ND)        exp_q[i] = 8'(48 + (r % 16) % 10);
            else if (i == 2 + ND)        exp_q[i] = mth[r % 8];
            else                         exp_q[i] = 8'(65 + (r % 32) % 26);
            if (int'(ep) >= 1 && int'(ep) <= LEN - 2 && i == int'(ep)) exp_q[i] = 8'h7E;
            l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
        end
    endtask

    // Recognizer model on the received string: 1 = STOP, 0 = ERROR
    function automatic bit recog();
        bit ok;
        ok = (got_q[0] == 8'h00) && (got_q[LEN-1] == 8'h00);
        ok = ok && (got_q[1] inside {8'h23, 8'h24, 8'h25, 8'h26, 8'h40});
        for (int i = 2; i <= 1 + ND; i++)
            ok = ok && (got_q[i] >= 8'h30) && (got_q[i] <= 8'h39);
        ok = ok && (got_q[2+ND] inside {8'h2B, 8'h2D, 8'h2A, 8'h2F, 8'h5C, 8'h3D, 8'h3C, 8'h3E});
        for (int i = 3 + ND; i < LEN - 1; i++)
            ok = ok && (got_q[i] >= 8'h41) && (got_q[i] <= 8'h5A);
        return ok;
    endfunction

    // mode 0: ready always 1, 1: random ready, 2: three-cycle stall at byte 2
    // abort_n >= 0 returns right after that many handshakes
    // chain=1 leaves the task in the done cycle so the caller can start at once
    task automatic run_string(input logic [7:0] s, input logic [3:0] ep, input int mode,
                              input bit poke_start, input int abort_n, input bit chain);
        int  n;
        int  cyc;
        int  hold;
        logic rdy;
        logic exp_ok;
        build_exp(s, ep);
        exp_ok = !(int'(ep) >= 1 && int'(ep) <= LEN - 2);
        seed    = s;
        err_pos = ep;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("accept_busy", 32'(busy), 32'd1);
        check("accept_expect_ok", 32'(expect_ok), 32'(exp_ok));
        n = 0; cyc = 0; hold = 0;
        while (n < LEN && cyc < 100) begin
            if (n == abort_n) return;
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ($urandom_range(0, 3) != 0);
                default: begin
                    if (n == 2 && hold < 3) begin rdy = 1'b0; hold++; end
                    else rdy = 1'b1;
                end
            endcase
            ready   = rdy;
            seed    = 8'($urandom);
            err_pos = 4'($urandom);
            if (poke_start) start = 1'($urandom_range(0, 1));
            check("valid", 32'(valid), 32'd1);
            check("busy", 32'(busy), 32'd1);
            check($sformatf("byte%0d", n), 32'(data), 32'(exp_q[n]));
            if (rdy) begin
                got_q[n] = data;
                n++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        if (n < LEN) check("timeout_handshakes", 32'(n), 32'(LEN));
        check("done_pulse", 32'(done), 32'd1);
        check("valid_end", 32'(valid), 32'd0);
        check("busy_end", 32'(busy), 32'd0);
        check("expect_ok_hold", 32'(expect_ok), 32'(exp_ok));
        if (!chain) begin
            @(posedge clk); #1;
            check("done_once", 32'(done), 32'd0);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1; start = 1'b0; seed = 8'h00; err_pos = 4'd0; ready = 1'b0;
        lit_q = '{8'h00, 8'h25, 8'h34, 8'h38, 8'h31, 8'h2F, 8'h48, 8'h4F, 8'h00};
        repeat (3) @(posedge clk);
        #1;
        check("rst_data", 32'(data), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_expect_ok", 32'(expect_ok), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Known string for seed 01, full throughput
        run_string(8'h01, 4'd0, 0, 1'b0, -1, 1'b0);
        for (int i = 0; i < LEN; i++) check($sformatf("t1_lit%0d", i), 32'(got_q[i]), 32'(lit_q[i]));

        // Stall on '4'
        run_string(8'h01, 4'd0, 2, 1'b0, -1, 1'b0);
        for (int i = 0; i < LEN; i++) check($sformatf("t2_lit%0d", i), 32'(got_q[i]), 32'(lit_q[i]));

        // Error injection at byte 3, then out-of-range position
        run_string(8'h01, 4'd3, 0, 1'b0, -1, 1'b0);
        check("t3_err_byte", 32'(got_q[3]), 32'h7E);
        check("t3_recog", 32'(recog()), 32'd0);
        run_string(8'h01, 4'd8, 0, 1'b0, -1, 1'b0);
        for (int i = 0; i < LEN; i++) check($sformatf("t3b_lit%0d", i), 32'(got_q[i]), 32'(lit_q[i]));

        // Zero seed, start pokes while busy, back-to-back start in done cycle
        run_string(8'h00, 4'd0, 1, 1'b1, -1, 1'b1);
        for (int i = 0; i < LEN; i++) check($sformatf("t4_lit%0d", i), 32'(got_q[i]), 32'(lit_q[i]));
        run_string(8'h5A, 4'd15, 1, 1'b1, -1, 1'b0);

        // Reset after byte 4 handshake
        run_string(8'h01, 4'd6, 0, 1'b0, 5, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t5_valid", 32'(valid), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        run_string(8'h01, 4'd0, 0, 1'b0, -1, 1'b0);
        for (int i = 0; i < LEN; i++) check($sformatf("t5_lit%0d", i), 32'(got_q[i]), 32'(lit_q[i]));

        // Recognizer loop over every seed
        for (int s = 0; s < 256; s++) begin
            run_string(8'(s), 4'd0, 1, 1'b0, -1, 1'b0);
            check("t6_stop", 32'(recog()), 32'd1);
            run_string(8'(s), 4'd2, 1, 1'b0, -1, 1'b0);
            check("t6_error", 32'(recog()), 32'd0);
        end

        // Random seeds and error positions
        for (int k = 0; k < 60; k++) begin
            logic [3:0] ep;
            ep = 4'($urandom);
            run_string(8'($urandom), ep, 1, 1'b1, -1, 1'($urandom_range(0, 1)));
            check("rand_recog", 32'(recog()), 32'(!(int'(ep) >= 1 && int'(ep) <= LEN - 2)));
        end
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
